// File: rtl/instr_mem_fetch.sv
// ---------------------------------------------------------------------------
// instr_mem_fetch
// Instruction memory between the fetch stage and the decoder.
//  - After reset the array is cleared by a one-word-per-cycle zero-fill sweep
//    (INIT). Fetch and load ports stay closed until the sweep is complete.
//  - The fetch port is valid/ready with a registered, one-cycle-latency
//    response. A held response is bit-stable, and a new request is accepted in
//    the same cycle that the current response is consumed, so one fetch per
//    cycle is sustained.
//  - The load port writes single words. Writes to addresses >= DEPTH are
//    dropped. A load and a fetch to the same word in the same cycle return the
//    old word (read-before-write).
// ---------------------------------------------------------------------------
module instr_mem_fetch #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 8,
    parameter int                DEPTH        = 256,
    parameter logic [DATA_W-1:0] ILLEGAL_WORD = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    // fetch response
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    // program load
    input  logic              ld_en,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    // status
    output logic              init_done
);

    // Index width into the implemented array. This is never wider than ADDR_W
    // because DEPTH <= 2^ADDR_W.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH held one bit wider than an address, so DEPTH == 2^ADDR_W still
    // compares correctly against a full-width unsigned address.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_cnt_q, sweep_cnt_d;

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q,  resp_data_d;
    logic              resp_err_q,   resp_err_d;

    // The array itself is not reset. The sweep clears it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic              run_s;
    logic              req_ready_s;
    logic              fire_s;
    logic              req_in_range_s;
    logic              ld_in_range_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [IDX_W-1:0]  ld_idx_s;

    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    assign run_s          = (state_q == ST_RUN);
    assign req_in_range_s = ({1'b0, req_addr} < DEPTH_X);
    assign ld_in_range_s  = ({1'b0, ld_addr}  < DEPTH_X);
    assign req_idx_s      = req_addr[IDX_W-1:0];
    assign ld_idx_s       = ld_addr[IDX_W-1:0];

    // A new request may enter only when the output register is empty or is
    // being drained in this same cycle.
    assign req_ready_s = run_s && (!resp_valid_q || resp_ready);
    assign fire_s      = req_valid && req_ready_s;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------

    // Next-state logic: sweep one word per cycle, then stay in RUN until reset.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (sweep_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d     = ST_INIT;
                sweep_cnt_d = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and sweep-counter registers. Reset restarts the sweep from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= {IDX_W{1'b0}};
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Memory write port
    // ---------------------------------------------------------------------

    // Write-port mux. In INIT the sweep clears one word per cycle. In RUN only
    // in-range loads write the array.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {IDX_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_q)
            ST_INIT: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = sweep_cnt_q;
                mem_wdata_s = {DATA_W{1'b0}};
            end
            ST_RUN: begin
                if (ld_en && ld_in_range_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = ld_idx_s;
                    mem_wdata_s = ld_data;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Array storage. It has no reset, and the read in the response path sees
    // the pre-edge contents.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // ---------------------------------------------------------------------
    // Response register
    // ---------------------------------------------------------------------

    // Response next-state logic: load on accept, drop valid on consume, and
    // otherwise hold every bit.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (fire_s) begin
            resp_valid_d = 1'b1;
            if (req_in_range_s) begin
                resp_data_d = mem_q[req_idx_s];
                resp_err_d  = 1'b0;
            end else begin
                resp_data_d = ILLEGAL_WORD;
                resp_err_d  = 1'b1;
            end
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // Response registers. An asynchronous reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= {DATA_W{1'b0}};
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign ld_ready   = run_s;
    assign init_done  = run_s;

endmodule
